apv_frame_emulator: RTL and testbench
=====================================

APV_FRAME_EMULATOR -- requirements
Module: apv_frame_emulator

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single clock; all logic on its rising edge.
REQ-002 SHALL have port RST, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port ENABLE, input, 1 bit: emulator run enable.
REQ-004 SHALL have port TRIGGER, input, 1 bit: one-cycle frame request, synchronous to CLK.
REQ-005 SHALL have port SYNC_PERIOD, input, 8 bits: tick spacing minus one, in clocks.
REQ-006 SHALL have port HIGH_LEVEL, input, 12 bits: ADC code for logic one and tick.
REQ-007 SHALL have port LOW_LEVEL, input, 12 bits: ADC code for logic zero and idle baseline.
REQ-008 SHALL have port BASELINE, input, 12 bits: analog pattern offset.
REQ-009 SHALL have port MARKER_CH, input, 8 bits: analog channel forced to HIGH_LEVEL.
REQ-010 SHALL have port APV_ERROR_N, input, 1 bit: value emitted in the error-bit slot (1 = no error).
REQ-011 SHALL have port ADC_PDATA, output, 12 bits: registered emulated APV sample stream.
REQ-012 SHALL have port FRAME_ACTIVE, output, 1 bit: high during the 140 frame slots.
REQ-013 SHALL have port FRAME_COUNT, output, 8 bits: frames emitted; also the frame address.
REQ-014 SHALL have port TRIG_PENDING, output, 4 bits: queued, not-yet-started triggers.
REQ-015 SHALL have port TRIG_OVERFLOW, output, 1 bit: sticky lost-trigger flag.

Function
REQ-016 SHALL run a free-running 8-bit period counter while ENABLE=1: counter==0 marks a tick slot and reloads SYNC_PERIOD; otherwise decrement. Slot spacing = SYNC_PERIOD+1 clocks; SYNC_PERIOD=0 gives a slot every clock.
REQ-017 SHALL, in IDLE at a tick slot with TRIG_PENDING=0, register ADC_PDATA=HIGH_LEVEL for one cycle; all other IDLE cycles SHALL output LOW_LEVEL.
REQ-018 SHALL, in IDLE at a tick slot with TRIG_PENDING>0, start a frame in that slot (no tick is emitted), decrement TRIG_PENDING, and assert FRAME_ACTIVE.
REQ-019 SHALL sequence the frame HEADER(3 slots, HIGH_LEVEL) -> ADDR(8 slots, FRAME_COUNT MSB first, 1=HIGH_LEVEL, 0=LOW_LEVEL) -> ERR(1 slot, from APV_ERROR_N sampled at frame start) -> ANALOG(128 slots) -> IDLE, for 140 cycles total.
REQ-020 SHALL output channel n (0..127) as BASELINE+n, truncated to 12 bits (wrap), except n==MARKER_CH, which outputs HIGH_LEVEL; MARKER_CH>=128 marks no channel.
REQ-021 SHALL increment FRAME_COUNT (8-bit wrap 255->0) on the last ANALOG slot; the address emitted is the pre-increment value.
REQ-022 SHALL keep the period counter running through frames; ticks are suppressed while FRAME_ACTIVE=1.
REQ-023 SHALL, on TRIGGER=1, increment TRIG_PENDING saturating at 15; a trigger at 15 is dropped and sets TRIG_OVERFLOW until RST.
REQ-024 SHALL, on TRIGGER coincident with a frame start, perform a net zero change to TRIG_PENDING.
REQ-025 SHALL, when ENABLE falls mid-frame, complete the frame, then hold IDLE at LOW_LEVEL with no ticks; TRIGGERs are ignored while ENABLE=0 and TRIG_PENDING is cleared.
REQ-026 SHALL, with ENABLE=0 in IDLE, hold the period counter at 0 so the first cycle after ENABLE rises is a tick slot.
REQ-027 SHALL take a SYNC_PERIOD change effect at the next reload only.

Reset
REQ-028 SHALL, with RST=1, immediately force ADC_PDATA=0, FRAME_ACTIVE=0, FRAME_COUNT=0, TRIG_PENDING=0, TRIG_OVERFLOW=0, period counter=0, and state IDLE, aborting any frame.
REQ-029 SHALL resume per REQ-026 on the first clock after RST deasserts.

Configuration
REQ-030 SHALL, with macro APV_EMU_TRIG_QUEUE_EN defined, behave per REQ-023/024 (queue depth 15).
REQ-031 SHALL, without APV_EMU_TRIG_QUEUE_EN, limit TRIG_PENDING to 0..1: a TRIGGER while it is 1 or FRAME_ACTIVE=1 is dropped and sets TRIG_OVERFLOW.

Verification
REQ-032 SHALL cover: ENABLE=1, SYNC_PERIOD=34, no trigger -> HIGH_LEVEL single cycles exactly 35 clocks apart, LOW_LEVEL otherwise.
REQ-033 SHALL cover: one TRIGGER, FRAME_COUNT=0xA5, APV_ERROR_N=1 -> at next tick slot 3 high, bits 1,0,1,0,0,1,0,1, one high, then 128 samples; FRAME_COUNT becomes 0xA6.
REQ-034 SHALL cover: BASELINE=0xFF0, MARKER_CH=5 -> channels 0..4 = 0xFF0..0xFF4, channel 5 = HIGH_LEVEL, channel 16 = 0x000 (wrap).
REQ-035 SHALL cover: 17 TRIGGERs in consecutive cycles with the queue macro defined -> TRIG_PENDING=15, TRIG_OVERFLOW=1, 15 back-to-back frames each starting on a tick slot; without the macro -> one frame and TRIG_OVERFLOW=1.
REQ-036 SHALL cover: RST pulse during ANALOG slot 60 -> all outputs zero within the same cycle; after release, first tick on the first clock.
REQ-037 SHALL cover: ENABLE falling at HEADER slot 2 -> frame completes all 140 slots, then constant LOW_LEVEL.

Source files
------------

// File: rtl/apv_frame_emulator.sv
// APV25 frame emulator: sync ticks plus triggered 140-slot frames on a 12-bit ADC stream.
// Define APV_EMU_TRIG_QUEUE_EN for a 15-deep trigger queue; otherwise a single pending trigger.
module apv_frame_emulator (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ENABLE,
  input  logic        TRIGGER,
  input  logic [7:0]  SYNC_PERIOD,
  input  logic [11:0] HIGH_LEVEL,
  input  logic [11:0] LOW_LEVEL,
  input  logic [11:0] BASELINE,
  input  logic [7:0]  MARKER_CH,
  input  logic        APV_ERROR_N,
  output logic [11:0] ADC_PDATA,
  output logic        FRAME_ACTIVE,
  output logic [7:0]  FRAME_COUNT,
  output logic [3:0]  TRIG_PENDING,
  output logic        TRIG_OVERFLOW
);

  typedef enum logic [2:0] {S_IDLE, S_HEADER, S_ADDR, S_ERR, S_ANALOG} state_t;

  state_t      state_q;
  logic [6:0]  idx_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  pend_q, pend_d;
  logic        ovf_q, ovf_d;
  logic        err_q;
  logic [11:0] pdata_q;
  logic        active_q;
  logic [7:0]  fc_q;

  logic        tick, start, trig, marker_hit, addr_bit;
  logic [11:0] analog;

  assign tick       = ENABLE && (cnt_q == '0);
  assign start      = (state_q == S_IDLE) && tick && (pend_q != '0);
  assign trig       = TRIGGER && ENABLE;
  assign marker_hit = (MARKER_CH == {1'b0, idx_q});
  assign analog     = BASELINE + {5'd0, idx_q};
  assign addr_bit   = fc_q[3'd7 - idx_q[2:0]];

  always_comb begin
    cnt_d  = '0;
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (ENABLE) begin
      cnt_d = (cnt_q == '0) ? SYNC_PERIOD : cnt_q - 8'd1;
`ifdef APV_EMU_TRIG_QUEUE_EN
      // A trigger landing on a frame start replaces the consumed entry.
      if (trig && !start) begin
        if (pend_q == 4'd15) ovf_d = 1'b1;
        else                 pend_d = pend_q + 4'd1;
      end else if (start && !trig) begin
        pend_d = pend_q - 4'd1;
      end
`else
      if (start) pend_d = '0;
      if (trig) begin
        if ((pend_q != '0) || active_q) ovf_d = 1'b1;
        else                            pend_d = 4'd1;
      end
`endif
    end else begin
      pend_d = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      pend_q   <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      pdata_q  <= '0;
      active_q <= 1'b0;
      fc_q     <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      case (state_q)
        S_IDLE: begin
          // The start edge itself emits header slot 0.
          if (start) begin
            state_q  <= S_HEADER;
            idx_q    <= 7'd1;
            err_q    <= APV_ERROR_N;
            pdata_q  <= HIGH_LEVEL;
            active_q <= 1'b1;
          end else begin
            idx_q    <= '0;
            pdata_q  <= tick ? HIGH_LEVEL : LOW_LEVEL;
            active_q <= 1'b0;
          end
        end
        S_HEADER: begin
          pdata_q <= HIGH_LEVEL;
          if (idx_q == 7'd2) begin
            state_q <= S_ADDR;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + 7'd1;
          end
        end
        S_ADDR: begin
          pdata_q <= addr_bit ? HIGH_LEVEL : LOW_LEVEL;
          if (idx_q == 7'd7) begin
            state_q <= S_ERR;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + 7'd1;
          end
        end
        S_ERR: begin
          pdata_q <= err_q ? HIGH_LEVEL : LOW_LEVEL;
          state_q <= S_ANALOG;
          idx_q   <= '0;
        end
        S_ANALOG: begin
          pdata_q <= marker_hit ? HIGH_LEVEL : analog;
          if (idx_q == 7'd127) begin
            fc_q    <= fc_q + 8'd1;
            state_q <= S_IDLE;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + 7'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign ADC_PDATA     = pdata_q;
  assign FRAME_ACTIVE  = active_q;
  assign FRAME_COUNT   = fc_q;
  assign TRIG_PENDING  = pend_q;
  assign TRIG_OVERFLOW = ovf_q;

endmodule

// File: tb/tb_apv_frame_emulator.sv
// Scoreboard bench for apv_frame_emulator: a slot-position reference model queues expected outputs per clock.
module tb_apv_frame_emulator;

  logic        CLK = 1'b0;
  logic        RST, ENABLE, TRIGGER, APV_ERROR_N;
  logic [7:0]  SYNC_PERIOD, MARKER_CH;
  logic [11:0] HIGH_LEVEL, LOW_LEVEL, BASELINE;
  logic [11:0] ADC_PDATA;
  logic        FRAME_ACTIVE, TRIG_OVERFLOW;
  logic [7:0]  FRAME_COUNT;
  logic [3:0]  TRIG_PENDING;

  apv_frame_emulator dut (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .TRIGGER(TRIGGER),
    .SYNC_PERIOD(SYNC_PERIOD), .HIGH_LEVEL(HIGH_LEVEL), .LOW_LEVEL(LOW_LEVEL),
    .BASELINE(BASELINE), .MARKER_CH(MARKER_CH), .APV_ERROR_N(APV_ERROR_N),
    .ADC_PDATA(ADC_PDATA), .FRAME_ACTIVE(FRAME_ACTIVE), .FRAME_COUNT(FRAME_COUNT),
    .TRIG_PENDING(TRIG_PENDING), .TRIG_OVERFLOW(TRIG_OVERFLOW)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [11:0] pd;
    logic        act;
    logic [7:0]  fc;
    logic [3:0]  pend;
    logic        ovf;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: m_pos is the next frame slot (0..139) to emit, -1 when idle.
  int m_cnt, m_pos, m_pend, m_fc, m_err;
  int m_pd, m_act, m_ovf;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int slot_val(input int p);
    int ch;
    if (p < 3) return HIGH_LEVEL;
    if (p < 11) return ((m_fc >> (10 - p)) & 1) ? HIGH_LEVEL : LOW_LEVEL;
    if (p == 11) return m_err ? HIGH_LEVEL : LOW_LEVEL;
    ch = p - 12;
    if (ch == MARKER_CH) return HIGH_LEVEL;
    return (BASELINE + ch) % 4096;
  endfunction

  task automatic model_step();
    exp_t e;
    int idle, tick, start, trig;
    if (RST) begin
      m_cnt = 0; m_pos = -1; m_pend = 0; m_ovf = 0; m_fc = 0; m_pd = 0; m_act = 0;
    end else begin
      idle  = (m_pos < 0);
      tick  = ENABLE && (m_cnt == 0);
      start = idle && tick && (m_pend > 0);
      trig  = TRIGGER && ENABLE;
      if (!ENABLE) m_pend = 0;
      else begin
`ifdef APV_EMU_TRIG_QUEUE_EN
        if (trig && !start) begin
          if (m_pend == 15) m_ovf = 1; else m_pend++;
        end else if (start && !trig) m_pend--;
`else
        if (trig && (m_pend > 0 || m_act)) m_ovf = 1;
        else if (trig) m_pend = 1;
        if (start) m_pend = 0;
`endif
      end
      if (idle) begin
        if (start) begin
          m_err = APV_ERROR_N; m_pd = slot_val(0); m_pos = 1; m_act = 1;
        end else begin
          m_pd = tick ? HIGH_LEVEL : LOW_LEVEL; m_act = 0;
        end
      end else begin
        m_pd = slot_val(m_pos);
        m_act = 1;
        if (m_pos == 139) begin m_fc = (m_fc + 1) % 256; m_pos = -1; end
        else m_pos++;
      end
      m_cnt = ENABLE ? ((m_cnt == 0) ? int'(SYNC_PERIOD) : m_cnt - 1) : 0;
    end
    e.pd = m_pd[11:0]; e.act = m_act[0]; e.fc = m_fc[7:0]; e.pend = m_pend[3:0]; e.ovf = m_ovf[0];
    q.push_back(e);
  endtask

  task automatic step();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic bound_ok(input string name, input int left);
    checks++;
    if (left <= 0) begin
      errors++;
      $display("FAIL %s: cycle budget expired", name);
    end
  endtask

  task automatic run_frames(input string name, input int budget);
    int n = budget;
    while ((m_pos >= 0 || m_pend > 0) && n > 0) begin step(); n--; end
    bound_ok(name, n);
  endtask

  task automatic trig_once();
    TRIGGER = 1'b1; step(); TRIGGER = 1'b0;
  endtask

  always @(negedge CLK) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp("ADC_PDATA", 32'(ADC_PDATA), 32'(e.pd));
      cmp("FRAME_ACTIVE", 32'(FRAME_ACTIVE), 32'(e.act));
      cmp("FRAME_COUNT", 32'(FRAME_COUNT), 32'(e.fc));
      cmp("TRIG_PENDING", 32'(TRIG_PENDING), 32'(e.pend));
      cmp("TRIG_OVERFLOW", 32'(TRIG_OVERFLOW), 32'(e.ovf));
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    RST = 1'b1; ENABLE = 1'b0; TRIGGER = 1'b0; APV_ERROR_N = 1'b1;
    SYNC_PERIOD = 8'd34; HIGH_LEVEL = 12'hE00; LOW_LEVEL = 12'h100;
    BASELINE = 12'h400; MARKER_CH = 8'd200;
    m_cnt = 0; m_pos = -1; m_pend = 0; m_fc = 0; m_err = 1; m_pd = 0; m_act = 0; m_ovf = 0;
    step(); step();
    RST = 1'b0;
    step();

    // Free-running ticks, 35 clocks apart.
    ENABLE = 1'b1;
    repeat (110) step();

    // Walk FRAME_COUNT up to 0xA5 with fast frames and varied levels.
    SYNC_PERIOD = 8'd0;
    n = 30000;
    while (m_fc != 8'hA5 && n > 0) begin
      if (m_pos < 0 && m_pend == 0 && !m_act) begin
        HIGH_LEVEL  = 12'($urandom_range(12'h800, 12'hFFF));
        LOW_LEVEL   = 12'($urandom_range(0, 12'h3FF));
        BASELINE    = 12'($urandom);
        MARKER_CH   = 8'($urandom);
        APV_ERROR_N = 1'($urandom);
        TRIGGER = 1'b1;
      end
      step();
      TRIGGER = 1'b0;
      n--;
    end
    bound_ok("reach_fc_A5", n);

    // Address 0xA5 frame with error bit clear.
    SYNC_PERIOD = 8'd34; APV_ERROR_N = 1'b1;
    HIGH_LEVEL = 12'hE00; LOW_LEVEL = 12'h100; BASELINE = 12'h400; MARKER_CH = 8'd200;
    repeat (5) step();
    trig_once();
    run_frames("frame_A5", 400);

    // Baseline wrap and marker channel.
    BASELINE = 12'hFF0; MARKER_CH = 8'd5;
    trig_once();
    run_frames("frame_wrap", 400);
    repeat (3) step();

    // Burst of 17 triggers inside a tick-free window.
    SYNC_PERIOD = 8'd200;
    n = 400;
    while (m_cnt != 200 && n > 0) begin step(); n--; end
    bound_ok("sync_window", n);
    repeat (17) trig_once();
    SYNC_PERIOD = 8'd3;
    run_frames("burst_frames", 4000);
    repeat (5) step();

    // Reset in the middle of analog channel 60.
    trig_once();
    n = 400;
    while (m_pos != 73 && n > 0) begin step(); n--; end
    bound_ok("reach_ch60", n);
    @(negedge CLK);
    #1 RST = 1'b1;
    #1;
    cmp("rst_ADC_PDATA", 32'(ADC_PDATA), 32'd0);
    cmp("rst_FRAME_ACTIVE", 32'(FRAME_ACTIVE), 32'd0);
    cmp("rst_FRAME_COUNT", 32'(FRAME_COUNT), 32'd0);
    cmp("rst_TRIG_PENDING", 32'(TRIG_PENDING), 32'd0);
    cmp("rst_TRIG_OVERFLOW", 32'(TRIG_OVERFLOW), 32'd0);
    step();
    RST = 1'b0;
    repeat (10) step();

    // ENABLE drops at header slot 2; frame must still run to completion.
    trig_once();
    n = 400;
    while (m_pos != 2 && n > 0) begin step(); n--; end
    bound_ok("reach_hdr2", n);
    ENABLE = 1'b0;
    repeat (200) begin
      TRIGGER = 1'($urandom_range(0, 7) == 0);
      step();
    end
    TRIGGER = 1'b0;
    ENABLE = 1'b1;

    // Randomised operation.
    repeat (4000) begin
      TRIGGER = 1'($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 299) == 0) ENABLE = ~ENABLE;
      if ($urandom_range(0, 99) == 0) SYNC_PERIOD = 8'($urandom_range(0, 20));
      if ($urandom_range(0, 199) == 0) MARKER_CH = 8'($urandom);
      if ($urandom_range(0, 199) == 0) BASELINE = 12'($urandom);
      APV_ERROR_N = 1'($urandom);
      step();
    end
    TRIGGER = 1'b0;

    @(negedge CLK);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
